// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants shared by fetch and control, plus the fetch FSM state type.
package mips_pkg;
  localparam logic [5:0] R_TYPE   = 6'h00;
  localparam logic [5:0] J        = 6'h02;
  localparam logic [5:0] JAL      = 6'h03;
  localparam logic [5:0] BEQ      = 6'h04;
  localparam logic [5:0] BNE      = 6'h05;
  localparam logic [5:0] ADDI     = 6'h08;
  localparam logic [5:0] ANDI     = 6'h0C;
  localparam logic [5:0] ORI      = 6'h0D;
  localparam logic [5:0] LUI      = 6'h0F;
  localparam logic [5:0] FUNCT_JR = 6'h08;
  typedef enum logic [1:0] {IDLE, FETCH, EXEC} fetch_state_t;
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational next-PC selection (jr > jump > taken branch > pc+4) and jr alignment check.
module next_pc_calc (
  input  logic [31:0] pc,
  input  logic [25:0] target,
  input  logic        jump,
  input  logic        branch_eq,
  input  logic        branch_ne,
  input  logic        alu_zero,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        align_err
);
  logic [31:0] br_off;
  logic        take_br;
  always_comb begin
    pc_plus4  = pc + 32'd4;
    br_off    = {{14{target[15]}}, target[15:0], 2'b00};
    take_br   = (branch_eq & alu_zero) | (branch_ne & ~alu_zero);
    next_pc   = jr ? {jr_target[31:2], 2'b00} :
                jump ? {pc_plus4[31:28], target, 2'b00} :
                take_br ? pc_plus4 + br_off : pc_plus4;
    align_err = jr & |jr_target[1:0];
  end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner and IDLE/FETCH/EXEC instruction fetch sequencer.
// Define FETCH_PERF_CNT_EN to add retired/stall performance counters.
module fetch_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        exec_hold,
  input  logic        jump,
  input  logic        jal,
  input  logic        branch_eq,
  input  logic        branch_ne,
  input  logic        alu_zero,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic        align_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
`endif
);
  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d, instr_q, instr_d, next_pc;
  logic         align_err_q, align_err_d, npc_align_err, retire;
  logic         unused_jal;
  assign unused_jal = jal;

  next_pc_calc u_npc (
    .pc        (pc_q),
    .target    (instr_q[25:0]),
    .jump      (jump),
    .branch_eq (branch_eq),
    .branch_ne (branch_ne),
    .alu_zero  (alu_zero),
    .jr        (jr),
    .jr_target (jr_target),
    .pc_plus4  (pc_plus4),
    .next_pc   (next_pc),
    .align_err (npc_align_err)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    align_err_d = 1'b0;
    retire      = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        instr_d = imem_ack ? imem_rdata : instr_q;
        state_d = imem_ack ? EXEC : FETCH;
      end
      EXEC: begin
        retire      = ~exec_hold;
        pc_d        = exec_hold ? pc_q : next_pc;
        state_d     = exec_hold ? EXEC : FETCH;
        align_err_d = ~exec_hold & npc_align_err;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      align_err_q <= align_err_d;
    end
  end

  assign imem_req    = state_q == FETCH;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = state_q == EXEC;
  assign pc          = pc_q;
  assign align_err   = align_err_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retired_cnt_q, retired_cnt_d, stall_cnt_q, stall_cnt_d;
  logic        stall;
  always_comb begin
    stall         = (imem_req & ~imem_ack) | (instr_valid & exec_hold);
    retired_cnt_d = retired_cnt_q + {31'd0, retire};
    stall_cnt_d   = stall_cnt_q + {31'd0, stall};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      retired_cnt_q <= retired_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end
  assign retired_cnt = retired_cnt_q;
  assign stall_cnt   = stall_cnt_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and random checks of fetch_sequencer against a transaction-level model.
module tb_fetch_sequencer;
  logic        clk = 0, reset = 1;
  logic        imem_req, imem_ack = 0, instr_valid, align_err;
  logic [31:0] imem_addr, imem_rdata = 0, instr, pc, pc_plus4, jr_target = 0;
  logic        exec_hold = 0, jump = 0, jal = 0, branch_eq = 0, branch_ne = 0, alu_zero = 0, jr = 0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif
  int total = 0, bad = 0;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .exec_hold(exec_hold),
    .jump(jump), .jal(jal), .branch_eq(branch_eq), .branch_ne(branch_ne),
    .alu_zero(alu_zero), .jr(jr), .jr_target(jr_target), .align_err(align_err)
`ifdef FETCH_PERF_CNT_EN
    , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Model: phase 0 = waiting to start, 1 = fetching, 2 = instruction executing.
  int          m_phase = 0;
  logic [31:0] m_pc = 32'h0040_0000, m_instr = 0, m_ret = 0, m_stall = 0;
  logic        m_aerr = 0;

  function automatic logic [31:0] ref_npc(logic [31:0] cur, logic [31:0] ins);
    logic [31:0] seq = cur + 32'd4;
    if (jr) return jr_target & ~32'd3;
    if (jump) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
    if ((branch_eq && alu_zero) || (branch_ne && !alu_zero))
      return seq + 32'(int'($signed(ins[15:0])) * 4);
    return seq;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check("imem_req", 32'(imem_req), 32'(m_phase == 1));
    check("imem_addr", imem_addr, m_pc);
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("instr", instr, m_instr);
    check("instr_valid", 32'(instr_valid), 32'(m_phase == 2));
    check("align_err", 32'(align_err), 32'(m_aerr));
`ifdef FETCH_PERF_CNT_EN
    check("retired_cnt", retired_cnt, m_ret);
    check("stall_cnt", stall_cnt, m_stall);
`endif
    if (reset) begin
      m_phase = 0; m_pc = 32'h0040_0000; m_instr = 0; m_aerr = 0; m_ret = 0; m_stall = 0;
    end else begin
      m_aerr = 0;
      if (m_phase == 0) m_phase = 1;
      else if (m_phase == 1) begin
        if (imem_ack) begin m_instr = imem_rdata; m_phase = 2; end
        else m_stall++;
      end else if (exec_hold) m_stall++;
      else begin
        m_aerr = jr && (jr_target[1:0] != 2'b00);
        m_pc = ref_npc(m_pc, m_instr);
        m_phase = 1;
        m_ret++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    jump = 0; jal = 0; branch_eq = 0; branch_ne = 0; alu_zero = 0; jr = 0; jr_target = 0; exec_hold = 0;
  endtask

  task automatic run_instr(input logic [31:0] w, input logic jp, input logic beq, input logic z,
                           input logic jrr, input logic [31:0] tgt);
    imem_ack = 1; imem_rdata = w; cyc();
    imem_ack = 0; jump = jp; jal = jp; branch_eq = beq; alu_zero = z; jr = jrr; jr_target = tgt; cyc();
    clr();
  endtask

  initial begin
    @(posedge clk); #1;
    cyc();
    check("rst_pc", pc, 32'h0040_0000);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    reset = 0; cyc();
    check("fetch_addr0", imem_addr, 32'h0040_0000);
    imem_ack = 1; imem_rdata = 32'h2008_0005; cyc();
    check("instr_addi", instr, 32'h2008_0005);
    check("exec_valid", 32'(instr_valid), 32'd1);
    imem_ack = 0; cyc();
    check("next_fetch", imem_addr, 32'h0040_0004);
    check("valid_drop", 32'(instr_valid), 32'd0);
    reset = 1; cyc(); reset = 0; cyc();
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("wait_req", 32'(imem_req), 32'd1);
      check("wait_addr", imem_addr, 32'h0040_0000);
    end
    imem_ack = 1; imem_rdata = 32'h2008_0005; cyc(); imem_ack = 0;
`ifdef FETCH_PERF_CNT_EN
    check("stall3", stall_cnt, 32'd3);
`endif
    cyc();
    run_instr(32'h2008_0005, 0, 0, 0, 0, 0);
    check("seq_pc", pc, 32'h0040_0008);
    run_instr(32'h1000_FFFE, 0, 1, 1, 0, 0);
    check("beq_taken", pc, 32'h0040_0004);
    run_instr(32'h2008_0005, 0, 0, 0, 0, 0);
    run_instr(32'h1000_FFFE, 0, 1, 0, 0, 0);
    check("beq_not", pc, 32'h0040_000C);
    run_instr(32'h0C10_0008, 1, 0, 0, 0, 0);
    check("j_pc", pc, 32'h0040_0020);
    imem_ack = 1; imem_rdata = 32'h0C10_0010; cyc();
    check("jal_p4", pc_plus4, 32'h0040_0024);
    imem_ack = 0; jump = 1; jal = 1; cyc(); clr();
    check("jal_pc", pc, 32'h0040_0040);
    run_instr(32'h03E0_0008, 1, 0, 0, 1, 32'h0040_0013);
    check("jr_pc", pc, 32'h0040_0010);
    check("aerr_hi", 32'(align_err), 32'd1);
    cyc();
    check("aerr_lo", 32'(align_err), 32'd0);
    imem_ack = 1; imem_rdata = 32'h1000_0003; cyc();
    imem_ack = 0; exec_hold = 1; jump = 1; jr = 1; jr_target = 32'h1234_5678; branch_eq = 1; alu_zero = 1;
    cyc(); cyc();
    check("hold_pc", pc, 32'h0040_0010);
    check("hold_instr", instr, 32'h1000_0003);
    check("hold_valid", 32'(instr_valid), 32'd1);
    clr(); cyc();
    reset = 1; imem_ack = 1; cyc();
    check("abort_pc", pc, 32'h0040_0000);
    check("abort_req", 32'(imem_req), 32'd0);
    reset = 0; imem_ack = 0; cyc();
    check("restart_req", 32'(imem_req), 32'd1);
    for (int i = 0; i < 4000; i++) begin
      reset = $urandom_range(63) == 0;
      imem_ack = $urandom_range(1);
      imem_rdata = $urandom;
      exec_hold = $urandom_range(3) == 0;
      jump = $urandom_range(3) == 0;
      jal = $urandom_range(1);
      branch_eq = $urandom_range(1);
      branch_ne = $urandom_range(1);
      alu_zero = $urandom_range(1);
      jr = $urandom_range(4) == 0;
      jr_target = $urandom;
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the program counter and instruction fetch for the MIPS core.
- Issues word reads to instruction memory with a req/ack handshake, latches the returned word, and presents it to the decoder and control unit for one execute window.
- At the end of the execute window it consumes the decoded control signals (jump, jal, BranchEQ, BranchNE) plus the ALU zero flag and jr request to compute the next PC.
- Sits directly upstream of the opcode decoder/control unit and downstream of its outputs for PC selection.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; every register samples on its rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; high exactly while state is FETCH.
- imem_addr  out  32  fetch address; equals pc; stable while imem_req is high.
- imem_ack  in  1  memory response valid; sampled only while imem_req is high.
- imem_rdata  in  32  instruction word; valid in the cycle imem_ack is high.
- instr  out  32  latched instruction; feeds the decoder (instr[31:26] is the opcode).
- instr_valid  out  1  high throughout EXEC.
- pc  out  32  address of the current instruction.
- pc_plus4  out  32  pc+4; also the jal link value for $ra.
- exec_hold  in  1  extends EXEC, for multi-cycle data memory.
- jump  in  1  control: unconditional jump (J or JAL).
- jal  in  1  control: link; no effect on the PC path beyond jump.
- branch_eq  in  1  control: BEQ.
- branch_ne  in  1  control: BNE.
- alu_zero  in  1  ALU zero flag.
- jr  in  1  jump-register request, from the ALU control on funct 0x08.
- jr_target  in  32  rs register value.
- align_err  out  1  one-cycle pulse on a misaligned jr target.

Behaviour:
- Reset: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, align_err=0.
  - Reset asserted in any state, including mid-handshake, aborts immediately.
  - An imem_ack arriving during reset is ignored.
- FSM states: IDLE, FETCH, EXEC.
  - IDLE: always goes to FETCH on the next cycle.
  - FETCH: imem_req=1 and imem_addr=pc. On imem_ack=1, instr<=imem_rdata and go to EXEC. Otherwise stay; addr and req are held.
  - EXEC: instr_valid=1. If exec_hold=1, stay; instr and pc are frozen and control inputs are ignored. If exec_hold=0, pc<=next_pc and go to FETCH.
- Throughput: a zero-wait ack and no hold gives 2 cycles per instruction.
- Latency: instr is visible the cycle after ack.
- next_pc priority, highest first:
  - jr → {jr_target[31:2],2'b00}.
  - jump → {pc_plus4[31:28], instr[25:0], 2'b00}.
  - (branch_eq & alu_zero) | (branch_ne & ~alu_zero) → pc_plus4 + (sign-extended instr[15:0] << 2).
  - Otherwise → pc_plus4.
- Arithmetic: all adds are 32-bit modulo; wrap past 32'hFFFF_FFFC to 0 is legal.
- Simultaneous branch_eq and branch_ne: the taken condition is the OR of both terms.
- align_err: pulses for one cycle at the EXEC→FETCH transition when jr=1 and jr_target[1:0]!=0. The PC is still updated with the low bits forced to 0.
- imem_ack outside FETCH: ignored.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined:
  - Adds outputs retired_cnt[31:0] and stall_cnt[31:0], both cleared by reset.
  - retired_cnt increments on each EXEC→FETCH transition.
  - stall_cnt increments on each FETCH cycle with imem_ack=0 and each EXEC cycle with exec_hold=1.
  - Both counters wrap modulo 2^32.
- When undefined: the ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - The opcode constants, also used by control: R_TYPE, ADDI, ORI, LUI, BEQ, BNE, ANDI, J, JAL.
  - FUNCT_JR=6'h08.
  - The fetch_state_t enum.
- One sub-module, next_pc_calc: purely combinational next_pc and align_err generation, unit-testable on its own.
- The FSM and registers live in fetch_sequencer.

Test Plan:
- Reset release, zero-wait ack with imem_rdata=32'h2008_0005 (addi) → imem_addr=32'h0040_0000, then instr_valid for 1 cycle, then next fetch address 32'h0040_0004.
- Ack delayed 3 cycles → imem_req and imem_addr stay 32'h0040_0000 for 4 cycles; stall_cnt=3 when FETCH_PERF_CNT_EN is defined.
- pc=32'h0040_0008, instr imm=16'hFFFE, branch_eq=1, alu_zero=1 → next pc 32'h0040_0004. Same with alu_zero=0 → 32'h0040_000C.
- instr=32'h0C10_0010 (jal), jump=1, jal=1, pc=32'h0040_0020 → pc_plus4=32'h0040_0024 during EXEC; next pc 32'h0040_0040.
- jr=1 and jump=1, jr_target=32'h0040_0013 → next pc 32'h0040_0010 and align_err pulses 1 cycle.
- exec_hold=1 for 2 cycles, then reset asserted mid-FETCH → instr and pc frozen during the hold; after reset pc=32'h0040_0000, imem_req=0 for 1 cycle.
